exit_door_ctrl: RTL and testbench
=================================

Name: exit_door_ctrl

Overview:
Exit-side door controller for the smart store, the counterpart of the entry door_open path. Opens the exit door when a customer steps on the inside pressure pad, holds it open while the pad is occupied or the doorway is obstructed, then drives it closed. Each exit is counted so the store occupancy logic can subtract departures.

Parameters:
DEBOUNCE_CYC, 4, consecutive synchronized samples needed to change the debounced pad level
HOLD_CYC, 20, cycles the door stays open after the pad and obstruction both clear
TRAVEL_CYC, 8, motor drive cycles for a full open or full close stroke
CNT_W, 8, width of exit counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pressure  input  1  inside pad, asynchronous, 1 = customer standing on pad
obstruct  input  1  doorway beam sensor, synchronous to clk, 1 = blocked
doorOpen  output  1  1 while the door is fully open (OPEN state)
motor_open  output  1  open drive, 1 only in OPENING
motor_close  output  1  close drive, 1 only in CLOSING
busy  output  1  1 in any state other than CLOSED
exit_count  output  CNT_W  number of exits since reset, saturating

Behaviour:
- Reset (async, rst_n=0): state CLOSED; all outputs 0; exit_count=0; synchronizer, debounce and timers cleared. Reset mid-stroke immediately drops both motor drives.
- pressure passes a 2-flop synchronizer. Debounced level pad_db changes only after the synchronized value differs from pad_db on DEBOUNCE_CYC consecutive edges; any agreeing sample clears the debounce counter. Glitches shorter than DEBOUNCE_CYC are ignored.
- Press event = pad_db 0->1. Worst-case latency from pressure rising to motor_open=1: 2+DEBOUNCE_CYC+1 cycles (7 at default).
- FSM, one transition per cycle:
  - CLOSED: on press event go to OPENING, load travel timer with TRAVEL_CYC, and increment exit_count by 1 unless it is all-ones.
  - OPENING: motor_open=1. Timer counts down. At 0, go to OPEN, load the hold timer.
  - OPEN: doorOpen=1. Hold timer reloads to HOLD_CYC while pad_db=1 or obstruct=1. Otherwise it counts down. At 0, go to CLOSING, load travel timer.
  - CLOSING: motor_close=1. If pad_db=1 or obstruct=1, go to OPENING the next cycle, loading the travel timer with TRAVEL_CYC minus the remaining close count. That is the reopen stroke, with a minimum of 1. No exit_count increment. Otherwise, at timer 0 go to CLOSED.
- motor_open and motor_close are never 1 in the same cycle. doorOpen is registered and is 0 during either stroke.
- A press event in OPENING, OPEN or CLOSING does not increment exit_count. A customer already in the doorway is not recounted.
- pad_db held high continuously: the door stays OPEN indefinitely. There is only one count for that press.
- obstruct is ignored in CLOSED and OPENING.
- exit_count saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset then pressure=1 held 3 cycles → no debounced press; stays CLOSED, exit_count=0, busy=0.
- pressure=1 held 30 cycles then 0 → motor_open=1 within 7 cycles for 8 cycles. doorOpen=1 until 20 cycles after pad_db falls. Then motor_close=1 for 8 cycles, then CLOSED, exit_count=1.
- During CLOSING, assert obstruct at close cycle 3 (5 remaining) → next cycle motor_open=1 for 3 cycles, then OPEN. Door closes only after obstruct clears plus 20 cycles. exit_count unchanged.
- Second pad press while OPEN → hold timer reloads, no count change. A later press from CLOSED → exit_count=2.
- Force 255 exits with CNT_W=8, then one more full cycle → exit_count stays 255.
- rst_n=0 asynchronously in the middle of OPENING → motor_open drops before the next clk edge. All outputs 0, exit_count=0; after release, the door stays CLOSED until a new debounced press.

Source files
------------

// File: rtl/exit_door_ctrl_if.sv
// Signal bundle between the exit door controller and its pad, beam and motor hardware.
// master drives the sensor inputs; slave is the controller.
interface exit_door_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pressure;
    logic             obstruct;
    logic             doorOpen;
    logic             motor_open;
    logic             motor_close;
    logic             busy;
    logic [CNT_W-1:0] exit_count;

    modport master (
        output pressure, obstruct,
        input  doorOpen, motor_open, motor_close, busy, exit_count
    );

    modport slave (
        input  pressure, obstruct,
        output doorOpen, motor_open, motor_close, busy, exit_count
    );
endinterface

// File: rtl/exit_door_ctrl.sv
// Exit door controller: debounces the inside pad, sequences the door motor and
// counts each customer exit with a saturating counter.
module exit_door_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned HOLD_CYC     = 20,
    parameter int unsigned TRAVEL_CYC   = 8,
    parameter int unsigned CNT_W        = 8
) (
    input logic             clk,
    input logic             rst_n,
    exit_door_ctrl_if.slave door
);

    localparam int unsigned TMR_MAX = (HOLD_CYC > TRAVEL_CYC) ? HOLD_CYC : TRAVEL_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {StClosed, StOpening, StOpen, StClosing} state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             pad_db_q, pad_prev_q;
    logic             door_open_q, motor_open_q, motor_close_q, busy_q;

    logic             press;
    logic             hold_req;
    logic [TMR_W-1:0] remain;
    logic [TMR_W-1:0] reopen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            pad_db_q   <= 1'b0;
            pad_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], door.pressure};
            pad_prev_q <= pad_db_q;
            // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
            if (sync_q[1] != pad_db_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                    pad_db_q <= sync_q[1];
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign press    = pad_db_q & ~pad_prev_q;
    assign hold_req = pad_db_q | door.obstruct;

    // Reopen stroke retraces only the distance already closed.
    assign remain = timer_q - TMR_W'(1);
    assign reopen = (remain >= TMR_W'(TRAVEL_CYC)) ? TMR_W'(1) : TMR_W'(TRAVEL_CYC) - remain;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClosed: begin
                if (press) begin
                    state_d = StOpening;
                    timer_d = TMR_W'(TRAVEL_CYC);
                    if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StOpening: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = StOpen;
                    timer_d = TMR_W'(HOLD_CYC);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StOpen: begin
                if (hold_req) begin
                    timer_d = TMR_W'(HOLD_CYC);
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = StClosing;
                    timer_d = TMR_W'(TRAVEL_CYC);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StClosing: begin
                if (hold_req) begin
                    state_d = StOpening;
                    timer_d = reopen;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = StClosed;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = StClosed;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StClosed;
            timer_q       <= '0;
            cnt_q         <= '0;
            door_open_q   <= 1'b0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            door_open_q   <= (state_d == StOpen);
            motor_open_q  <= (state_d == StOpening);
            motor_close_q <= (state_d == StClosing);
            busy_q        <= (state_d != StClosed);
        end
    end

    assign door.doorOpen    = door_open_q;
    assign door.motor_open  = motor_open_q;
    assign door.motor_close = motor_close_q;
    assign door.busy        = busy_q;
    assign door.exit_count  = cnt_q;

endmodule

// File: tb/tb_exit_door_ctrl.sv
// Directed bench for exit_door_ctrl; inputs change and outputs are sampled on negedges.
module tb_exit_door_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exit_door_ctrl_if #(.CNT_W(8)) dif ();

    exit_door_ctrl #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (20),
        .TRAVEL_CYC  (8),
        .CNT_W       (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .door (dif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.pressure = 1'b0;
        dif.obstruct = 1'b0;
        repeat (3) tick();
        checks++; if (dif.doorOpen !== 1'b0) begin failures++; $display("FAIL reset_door: got %0b want 0", dif.doorOpen); end
        checks++; if (dif.motor_open !== 1'b0) begin failures++; $display("FAIL reset_mopen: got %0b want 0", dif.motor_open); end
        checks++; if (dif.motor_close !== 1'b0) begin failures++; $display("FAIL reset_mclose: got %0b want 0", dif.motor_close); end
        checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", dif.busy); end
        checks++; if (dif.exit_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dif.exit_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        dif.pressure = 1'b1;
        repeat (3) tick();
        dif.pressure = 1'b0;
        dif.obstruct = 1'b1;  // also shows obstruct alone does not open the door
        repeat (20) begin
            tick();
            if (dif.busy || dif.motor_open) seen = 1'b1;
        end
        dif.obstruct = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_active: got %0b want 0", seen); end
        checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy: got %0b want 0", dif.busy); end
        checks++; if (dif.exit_count !== 8'd0) begin failures++; $display("FAIL glitch_count: got %0d want 0", dif.exit_count); end
    endtask

    task automatic test_open_close();
        int first_mo = 0, n_mo = 0, first_do = 0, n_do = 0, first_mc = 0, n_mc = 0;
        logic both = 1'b0;
        dif.pressure = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (dif.motor_open) begin if (first_mo == 0) first_mo = k; n_mo++; end
            if (dif.doorOpen) begin if (first_do == 0) first_do = k; n_do++; end
            if (dif.motor_close) begin if (first_mc == 0) first_mc = k; n_mc++; end
            if (dif.motor_open && dif.motor_close) both = 1'b1;
            if (dif.doorOpen && (dif.motor_open || dif.motor_close)) both = 1'b1;
            if (k == 30) dif.pressure = 1'b0;
        end
        checks++; if (first_mo != 7) begin failures++; $display("FAIL oc_open_latency: got %0d want 7", first_mo); end
        checks++; if (n_mo != 8) begin failures++; $display("FAIL oc_open_len: got %0d want 8", n_mo); end
        checks++; if (first_do != 15) begin failures++; $display("FAIL oc_door_start: got %0d want 15", first_do); end
        checks++; if (n_do != 41) begin failures++; $display("FAIL oc_door_len: got %0d want 41", n_do); end
        checks++; if (first_mc != 56) begin failures++; $display("FAIL oc_close_start: got %0d want 56", first_mc); end
        checks++; if (n_mc != 8) begin failures++; $display("FAIL oc_close_len: got %0d want 8", n_mc); end
        checks++; if (both !== 1'b0) begin failures++; $display("FAIL oc_exclusive: got %0b want 0", both); end
        checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL oc_busy: got %0b want 0", dif.busy); end
        checks++; if (dif.exit_count !== 8'd1) begin failures++; $display("FAIL oc_count: got %0d want 1", dif.exit_count); end
    endtask

    task automatic test_second_press();
        int n_mo = 0;
        dif.pressure = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (dif.motor_open) n_mo++;
            if (k == 20) begin
                checks++; if (dif.doorOpen !== 1'b1) begin failures++; $display("FAIL sp_open_k20: got %0b want 1", dif.doorOpen); end
            end
            if (k == 45) begin
                checks++; if (dif.doorOpen !== 1'b1) begin failures++; $display("FAIL sp_reload_k45: got %0b want 1", dif.doorOpen); end
                checks++; if (dif.exit_count !== 8'd2) begin failures++; $display("FAIL sp_count_k45: got %0d want 2", dif.exit_count); end
            end
            if (k == 55) begin
                checks++; if (dif.doorOpen !== 1'b1) begin failures++; $display("FAIL sp_open_k55: got %0b want 1", dif.doorOpen); end
            end
            if (k == 56) begin
                checks++; if (dif.motor_close !== 1'b1) begin failures++; $display("FAIL sp_close_k56: got %0b want 1", dif.motor_close); end
            end
            if (k == 64) begin
                checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL sp_closed_k64: got %0b want 0", dif.busy); end
            end
            if (k == 10 || k == 30) dif.pressure = 1'b0;
            if (k == 20) dif.pressure = 1'b1;
        end
        checks++; if (n_mo != 8) begin failures++; $display("FAIL sp_single_stroke: got %0d want 8", n_mo); end
        checks++; if (dif.exit_count !== 8'd2) begin failures++; $display("FAIL sp_count: got %0d want 2", dif.exit_count); end
    endtask

    task automatic test_reopen();
        int n = 0, guard = 0, runlen = 0;
        dif.pressure = 1'b1;
        repeat (10) tick();
        dif.pressure = 1'b0;
        while (n < 3 && guard < 200) begin
            tick();
            guard++;
            if (dif.motor_close) n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL ro_reach_close: got %0d want 3", n); end
        dif.obstruct = 1'b1;
        tick();
        checks++; if (dif.motor_open !== 1'b1) begin failures++; $display("FAIL ro_mopen: got %0b want 1", dif.motor_open); end
        checks++; if (dif.motor_close !== 1'b0) begin failures++; $display("FAIL ro_mclose: got %0b want 0", dif.motor_close); end
        guard = 0;
        while (dif.motor_open && guard < 50) begin
            runlen++;
            guard++;
            tick();
        end
        checks++; if (runlen != 3) begin failures++; $display("FAIL ro_stroke_len: got %0d want 3", runlen); end
        checks++; if (dif.doorOpen !== 1'b1) begin failures++; $display("FAIL ro_door: got %0b want 1", dif.doorOpen); end
        repeat (10) tick();
        dif.obstruct = 1'b0;
        n = 0;
        guard = 0;
        while (dif.doorOpen && guard < 100) begin
            n++;
            guard++;
            tick();
        end
        checks++; if (n != 20) begin failures++; $display("FAIL ro_hold_len: got %0d want 20", n); end
        checks++; if (dif.motor_close !== 1'b1) begin failures++; $display("FAIL ro_closing: got %0b want 1", dif.motor_close); end
        guard = 0;
        while (dif.busy && guard < 50) begin
            guard++;
            tick();
        end
        checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL ro_closed: got %0b want 0", dif.busy); end
        checks++; if (dif.exit_count !== 8'd3) begin failures++; $display("FAIL ro_count: got %0d want 3", dif.exit_count); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        logic seen = 1'b0;
        dif.pressure = 1'b1;
        while (!dif.motor_open && guard < 20) begin
            guard++;
            tick();
        end
        checks++; if (dif.motor_open !== 1'b1) begin failures++; $display("FAIL ar_opening: got %0b want 1", dif.motor_open); end
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        dif.pressure = 1'b0;
        #1;
        checks++; if (dif.motor_open !== 1'b0) begin failures++; $display("FAIL ar_mopen_drop: got %0b want 0", dif.motor_open); end
        checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL ar_busy: got %0b want 0", dif.busy); end
        checks++; if (dif.doorOpen !== 1'b0) begin failures++; $display("FAIL ar_door: got %0b want 0", dif.doorOpen); end
        checks++; if (dif.exit_count !== 8'd0) begin failures++; $display("FAIL ar_count: got %0d want 0", dif.exit_count); end
        tick();
        rst_n = 1'b1;
        repeat (30) begin
            tick();
            if (dif.busy || dif.motor_open || dif.motor_close) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ar_stays_closed: got %0b want 0", seen); end
    endtask

    task automatic test_saturation();
        int timeouts = 0;
        int guard;
        for (int i = 1; i <= 256; i++) begin
            dif.pressure = 1'b1;
            repeat (5) tick();
            dif.pressure = 1'b0;
            guard = 0;
            while (!dif.busy && guard < 20) begin guard++; tick(); end
            if (!dif.busy) timeouts++;
            guard = 0;
            while (dif.busy && guard < 200) begin guard++; tick(); end
            if (dif.busy) timeouts++;
            if (i == 254) begin
                checks++; if (dif.exit_count !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d want 254", dif.exit_count); end
            end
            if (i == 255) begin
                checks++; if (dif.exit_count !== 8'd255) begin failures++; $display("FAIL sat_255: got %0d want 255", dif.exit_count); end
            end
        end
        checks++; if (timeouts != 0) begin failures++; $display("FAIL sat_timeouts: got %0d want 0", timeouts); end
        checks++; if (dif.exit_count !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d want 255", dif.exit_count); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_open_close();
        test_second_press();
        test_reopen();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
